// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for the two-client RAM arbiter.
//   state_t  : controller state (post-reset clear sweep, normal service)
//   client_t : requester identity, also the round-robin priority pointer
package ram_arb_pkg;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  typedef enum logic {
    CL_A,
    CL_B
  } client_t;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst_n : clock, asynchronous active-low reset
//   req[1:0]   : requests, bit 0 = client A, bit 1 = client B
//   gnt[1:0]   : one-hot or zero grant, combinational on req
// The priority pointer only matters when both clients request. After any
// grant, it moves to the client that was not served.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  client_t ptr;

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = (ptr == CL_A) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= CL_A;
    end else if (gnt[0]) begin
      ptr <= CL_B;
    end else if (gnt[1]) begin
      ptr <= CL_A;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin front end for a simple dual-port RAM.
// The RAM has one synchronous write port and one asynchronous read port.
// At most one client access is granted per cycle.
//   a_req/a_we/a_addr/a_wdata : client A request (held until a_gnt)
//   a_gnt                     : A accepted this cycle (combinational)
//   a_rvalid/a_rdata          : registered read return, one cycle after grant
//   b_*                       : the same set of ports for client B
//   ram_wen/ram_din/ram_addrin: RAM write port
//   ram_addrout/ram_dout      : RAM asynchronous read port
//   busy                      : post-reset zero-fill sweep running; no grants
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int RAM_WIDTH      = 8,
  parameter int RAM_ADDR_WIDTH = 3,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      a_req,
  input  logic                      a_we,
  input  logic [RAM_ADDR_WIDTH-1:0] a_addr,
  input  logic [RAM_WIDTH-1:0]      a_wdata,
  output logic                      a_gnt,
  output logic                      a_rvalid,
  output logic [RAM_WIDTH-1:0]      a_rdata,
  input  logic                      b_req,
  input  logic                      b_we,
  input  logic [RAM_ADDR_WIDTH-1:0] b_addr,
  input  logic [RAM_WIDTH-1:0]      b_wdata,
  output logic                      b_gnt,
  output logic                      b_rvalid,
  output logic [RAM_WIDTH-1:0]      b_rdata,
  output logic                      ram_wen,
  output logic [RAM_WIDTH-1:0]      ram_din,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addrin,
  output logic [RAM_ADDR_WIDTH-1:0] ram_addrout,
  input  logic [RAM_WIDTH-1:0]      ram_dout,
  output logic                      busy
);

  localparam logic [RAM_ADDR_WIDTH-1:0] LAST_ADDR   = '1;
  localparam state_t                    RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

  state_t                    state;
  state_t                    state_nxt;
  logic [RAM_ADDR_WIDTH-1:0] clr_cnt;
  logic [RAM_ADDR_WIDTH-1:0] clr_cnt_nxt;
  logic                      run;
  logic [1:0]                req;
  logic [1:0]                gnt;

  // Requests are masked while rst_n is low so that a request present
  // during reset can neither be granted nor reach the RAM write port.
  assign run = (state == ST_RUN) && rst_n;
  assign req = {b_req, a_req} & {2{run}};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign a_gnt = gnt[0];
  assign b_gnt = gnt[1];

  // Controller state and sweep counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RESET_STATE;
      clr_cnt <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    if (state == ST_CLEAR) begin
      clr_cnt_nxt = clr_cnt + 1'b1;
      if (clr_cnt == LAST_ADDR) begin
        state_nxt   = ST_RUN;
        clr_cnt_nxt = '0;
      end
    end
  end

  // RAM port mux: sweep, granted client, or all-zero when idle
  always_comb begin
    busy        = 1'b0;
    ram_wen     = 1'b0;
    ram_din     = '0;
    ram_addrin  = '0;
    ram_addrout = '0;
    if (state == ST_CLEAR) begin
      busy       = 1'b1;
      ram_wen    = 1'b1;
      ram_addrin = clr_cnt;
    end else if (a_gnt) begin
      if (a_we) begin
        ram_wen    = 1'b1;
        ram_addrin = a_addr;
        ram_din    = a_wdata;
      end else begin
        ram_addrout = a_addr;
      end
    end else if (b_gnt) begin
      if (b_we) begin
        ram_wen    = 1'b1;
        ram_addrin = b_addr;
        ram_din    = b_wdata;
      end else begin
        ram_addrout = b_addr;
      end
    end
  end

  // Per-client read return registers; rdata holds between reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rvalid <= 1'b0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt && !a_we) begin
        a_rdata <= ram_dout;
      end
      if (b_gnt && !b_we) begin
        b_rdata <= ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: randomized self-checking bench for ram_arbiter.
// The bench also plays the RAM: synchronous write, asynchronous read.
module tb_ram_arbiter;

  localparam int W  = 8;
  localparam int AW = 3;
  localparam int D  = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [W-1:0]  a_wdata = '0, b_wdata = '0;
  logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_wen, busy;
  logic [W-1:0]  a_rdata, b_rdata, ram_din, ram_dout;
  logic [AW-1:0] ram_addrin, ram_addrout;

  // RAM model; junk_* lets the bench pre-load non-zero garbage
  logic [W-1:0]  mem [D];
  logic          junk_en = 1'b0;
  logic [AW-1:0] junk_addr = '0;
  logic [W-1:0]  junk_data = '0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (junk_en) mem[junk_addr] <= junk_data;
    else if (ram_wen) mem[ram_addrin] <= ram_din;
  end
  assign ram_dout = mem[ram_addrout];

  ram_arbiter #(
    .RAM_WIDTH      (W),
    .RAM_ADDR_WIDTH (AW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a_req       (a_req),
    .a_we        (a_we),
    .a_addr      (a_addr),
    .a_wdata     (a_wdata),
    .a_gnt       (a_gnt),
    .a_rvalid    (a_rvalid),
    .a_rdata     (a_rdata),
    .b_req       (b_req),
    .b_we        (b_we),
    .b_addr      (b_addr),
    .b_wdata     (b_wdata),
    .b_gnt       (b_gnt),
    .b_rvalid    (b_rvalid),
    .b_rdata     (b_rdata),
    .ram_wen     (ram_wen),
    .ram_din     (ram_din),
    .ram_addrin  (ram_addrin),
    .ram_addrout (ram_addrout),
    .ram_dout    (ram_dout),
    .busy        (busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: memory contents, priority owner, expected returns
  logic [W-1:0]  ref_mem [D];
  int            ref_ptr;          // 0 = A has priority, 1 = B
  logic          ref_busy;
  logic          g_a, g_b;
  logic          e_wen;
  logic [AW-1:0] e_addrin, e_addrout;
  logic [W-1:0]  e_din;
  logic          e_arv, e_brv;
  logic [W-1:0]  e_ard, e_brd;
  logic          a_act, b_act;

  task model_reset();
    ref_ptr  = 0;
    ref_busy = 1'b1;
    g_a = 1'b0; g_b = 1'b0;
    e_arv = 1'b0; e_brv = 1'b0;
    e_ard = '0; e_brd = '0;
  endtask

  // Expected grants and RAM pins for the inputs currently driven
  task predict();
    g_a = !ref_busy && a_req && (!b_req || ref_ptr == 0);
    g_b = !ref_busy && b_req && !g_a;
    e_wen = (g_a && a_we) || (g_b && b_we);
    e_addrin = '0; e_din = '0; e_addrout = '0;
    if (g_a && a_we) begin e_addrin = a_addr; e_din = a_wdata; end
    if (g_b && b_we) begin e_addrin = b_addr; e_din = b_wdata; end
    if (g_a && !a_we) e_addrout = a_addr;
    if (g_b && !b_we) e_addrout = b_addr;
  endtask

  // Consume one clock edge in the model, returns 1ns after the edge
  task advance();
    @(posedge clk);
    e_arv = g_a && !a_we;
    e_brv = g_b && !b_we;
    if (e_arv) e_ard = ref_mem[a_addr];
    if (e_brv) e_brd = ref_mem[b_addr];
    if (g_a && a_we) ref_mem[a_addr] = a_wdata;
    if (g_b && b_we) ref_mem[b_addr] = b_wdata;
    if (g_a) ref_ptr = 1;
    else if (g_b) ref_ptr = 0;
    #1;
  endtask

  // Random requester behaviour: new request only once the old one is granted
  task drive_clients(input int pct, input bit allow_write);
    if (!a_act && $urandom_range(0, 99) < pct) begin
      a_act = 1'b1;
      a_we = allow_write ? 1'($urandom_range(0, 1)) : 1'b0;
      a_addr = AW'($urandom);
      a_wdata = W'($urandom);
    end
    if (!b_act && $urandom_range(0, 99) < pct) begin
      b_act = 1'b1;
      b_we = allow_write ? 1'($urandom_range(0, 1)) : 1'b0;
      b_addr = AW'($urandom);
      b_wdata = W'($urandom);
    end
    a_req = a_act;
    b_req = b_act;
  endtask

  task test_reset();
    #2;
    rst_n = 1'b0;
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b1;
    model_reset();
    #1;
    vectors++;
    if ({busy, a_gnt, b_gnt, a_rvalid, b_rvalid} !== 5'b10000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 10000", {busy, a_gnt, b_gnt, a_rvalid, b_rvalid});
    end
    vectors++;
    if ({a_rdata, b_rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_rdata: got %h/%h expected 00/00", a_rdata, b_rdata);
    end
    vectors++;
    if ({ram_wen, ram_addrin, ram_din, ram_addrout} !== {1'b1, 3'd0, 8'h00, 3'd0}) begin
      miscompares++;
      $display("FAIL reset_ram: got wen=%b ain=%h din=%h aout=%h expected 1/0/00/0",
               ram_wen, ram_addrin, ram_din, ram_addrout);
    end
    // Fill the RAM with non-zero garbage so the sweep has work to do
    for (int i = 0; i < D; i++) begin
      junk_en = 1'b1;
      junk_addr = AW'(i);
      junk_data = W'($urandom) | 8'h01;
      @(posedge clk);
      #1;
    end
    junk_en = 1'b0;
    a_req = 1'b0; b_req = 1'b0;
  endtask

  task test_sweep();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = '0;
    for (int i = 0; i < D; i++) begin
      #1;
      vectors++;
      if ({busy, a_gnt, b_gnt, ram_wen, ram_addrin, ram_din} !== {4'b1001, AW'(i), 8'h00}) begin
        miscompares++;
        $display("FAIL sweep_%0d: got busy=%b gnt=%b%b wen=%b ain=%0d din=%h expected busy=1 gnt=00 wen=1 ain=%0d din=00",
                 i, busy, a_gnt, b_gnt, ram_wen, ram_addrin, ram_din, i);
      end
      @(posedge clk);
    end
    #1;
    a_req = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL sweep_end: busy got %b expected 0", busy);
    end
    ref_busy = 1'b0;
    for (int i = 0; i < D; i++) ref_mem[i] = '0;
  endtask

  task test_read_zero();
    for (int i = 0; i <= D; i++) begin
      a_req = (i < D); a_we = 1'b0; a_addr = AW'(i); b_req = 1'b0;
      #1;
      predict();
      vectors++;
      if ({a_gnt, b_gnt} !== {g_a, g_b}) begin
        miscompares++;
        $display("FAIL zero_gnt_%0d: got %b%b expected %b%b", i, a_gnt, b_gnt, g_a, g_b);
      end
      vectors++;
      if (a_rvalid !== e_arv || (e_arv && a_rdata !== 8'h00)) begin
        miscompares++;
        $display("FAIL zero_read_%0d: got rvalid=%b rdata=%h expected rvalid=%b rdata=00",
                 i, a_rvalid, a_rdata, e_arv);
      end
      advance();
    end
  endtask

  task test_write_read();
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd3; a_wdata = 8'hA5; b_req = 1'b0;
    #1;
    predict();
    vectors++;
    if ({a_gnt, ram_wen, ram_addrin, ram_din} !== {1'b1, 1'b1, 3'd3, 8'hA5}) begin
      miscompares++;
      $display("FAIL wr_cycle: got gnt=%b wen=%b ain=%0d din=%h expected 1/1/3/a5",
               a_gnt, ram_wen, ram_addrin, ram_din);
    end
    advance();
    a_we = 1'b0;
    #1;
    predict();
    vectors++;
    if ({a_gnt, ram_wen, ram_addrout} !== {1'b1, 1'b0, 3'd3}) begin
      miscompares++;
      $display("FAIL rd_cycle: got gnt=%b wen=%b aout=%0d expected 1/0/3", a_gnt, ram_wen, ram_addrout);
    end
    advance();
    a_req = 1'b0;
    #1;
    predict();
    vectors++;
    if ({a_rvalid, a_rdata, b_rvalid} !== {1'b1, 8'hA5, 1'b0}) begin
      miscompares++;
      $display("FAIL wr_rd_return: got rvalid=%b rdata=%h b_rvalid=%b expected 1/a5/0",
               a_rvalid, a_rdata, b_rvalid);
    end
    advance();
    vectors++;
    if (a_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL rvalid_pulse: got %b expected 0", a_rvalid);
    end
  endtask

  task test_random();
    a_act = 1'b0; b_act = 1'b0;
    for (int n = 0; n < 300; n++) begin
      drive_clients(60, 1'b1);
      #1;
      predict();
      vectors++;
      if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata} !== {g_a, g_b, e_arv, e_brv, e_ard, e_brd}) begin
        miscompares++;
        $display("FAIL rand_client_%0d: got gnt=%b%b rv=%b%b rd=%h/%h expected gnt=%b%b rv=%b%b rd=%h/%h",
                 n, a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, g_a, g_b, e_arv, e_brv, e_ard, e_brd);
      end
      vectors++;
      if ({ram_wen, ram_addrin, ram_din, ram_addrout} !== {e_wen, e_addrin, e_din, e_addrout}) begin
        miscompares++;
        $display("FAIL rand_ram_%0d: got wen=%b ain=%0d din=%h aout=%0d expected wen=%b ain=%0d din=%h aout=%0d",
                 n, ram_wen, ram_addrin, ram_din, ram_addrout, e_wen, e_addrin, e_din, e_addrout);
      end
      advance();
      if (g_a) a_act = 1'b0;
      if (g_b) b_act = 1'b0;
    end
    a_req = 1'b0; b_req = 1'b0;
    #1;
    predict();
    advance();
    for (int i = 0; i < D; i++) begin
      vectors++;
      if (mem[i] !== ref_mem[i]) begin
        miscompares++;
        $display("FAIL ram_content_%0d: got %h expected %h", i, mem[i], ref_mem[i]);
      end
    end
  endtask

  task test_alternate();
    logic prev_a;
    prev_a = 1'b0;
    a_act = 1'b0; b_act = 1'b0;
    for (int n = 0; n < 12; n++) begin
      drive_clients(100, 1'b0);
      #1;
      predict();
      vectors++;
      if ({a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata} !== {g_a, g_b, e_arv, e_brv, e_ard, e_brd}) begin
        miscompares++;
        $display("FAIL alt_%0d: got gnt=%b%b rv=%b%b rd=%h/%h expected gnt=%b%b rv=%b%b rd=%h/%h",
                 n, a_gnt, b_gnt, a_rvalid, b_rvalid, a_rdata, b_rdata, g_a, g_b, e_arv, e_brv, e_ard, e_brd);
      end
      if (n > 0) begin
        vectors++;
        if (a_gnt === prev_a) begin
          miscompares++;
          $display("FAIL alt_turn_%0d: a_gnt got %b expected %b", n, a_gnt, !prev_a);
        end
      end
      prev_a = a_gnt;
      advance();
      if (g_a) a_act = 1'b0;
      if (g_b) b_act = 1'b0;
    end
    a_req = 1'b0; b_req = 1'b0;
    #1;
    predict();
    advance();
  endtask

  task test_conflict();
    if (ref_ptr != 0) begin
      b_req = 1'b1; b_we = 1'b0; b_addr = '0; a_req = 1'b0;
      #1;
      predict();
      advance();
      b_req = 1'b0;
    end
    a_req = 1'b1; a_we = 1'b1; a_addr = 3'd5; a_wdata = 8'h3C;
    b_req = 1'b1; b_we = 1'b0; b_addr = 3'd5;
    #1;
    predict();
    vectors++;
    if ({a_gnt, b_gnt} !== 2'b10) begin
      miscompares++;
      $display("FAIL conflict_first: got %b%b expected 10", a_gnt, b_gnt);
    end
    advance();
    a_req = 1'b0;
    #1;
    predict();
    vectors++;
    if ({a_gnt, b_gnt, ram_addrout} !== {2'b01, 3'd5}) begin
      miscompares++;
      $display("FAIL conflict_second: got gnt=%b%b aout=%0d expected 01/5", a_gnt, b_gnt, ram_addrout);
    end
    advance();
    b_req = 1'b0;
    #1;
    predict();
    vectors++;
    if ({b_rvalid, b_rdata} !== {1'b1, 8'h3C}) begin
      miscompares++;
      $display("FAIL conflict_data: got rvalid=%b rdata=%h expected 1/3c", b_rvalid, b_rdata);
    end
    advance();
  endtask

  task test_b_reads();
    logic [AW-1:0] addrs [3];
    addrs[0] = 3'd1; addrs[1] = 3'd2; addrs[2] = 3'd7;
    a_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b_req = (i < 3); b_we = 1'b0; b_addr = addrs[(i < 3) ? i : 0];
      #1;
      predict();
      vectors++;
      if (b_gnt !== (i < 3)) begin
        miscompares++;
        $display("FAIL b_only_gnt_%0d: got %b expected %b", i, b_gnt, (i < 3));
      end
      if (i > 0) begin
        vectors++;
        if ({b_rvalid, b_rdata} !== {1'b1, ref_mem[addrs[i-1]]}) begin
          miscompares++;
          $display("FAIL b_only_data_%0d: got rvalid=%b rdata=%h expected 1/%h",
                   i, b_rvalid, b_rdata, ref_mem[addrs[i-1]]);
        end
      end
      advance();
    end
    b_req = 1'b0;
  endtask

  task test_reset_mid_sweep();
    a_req = 1'b1; a_we = 1'b0; a_addr = 3'd3; b_req = 1'b0;
    #1;
    predict();
    advance();
    a_req = 1'b0;
    vectors++;
    if (a_rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL pre_reset_rvalid: got %b expected 1", a_rvalid);
    end
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({a_rvalid, a_rdata, busy} !== {1'b0, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_drop: got rvalid=%b rdata=%h busy=%b expected 0/00/1", a_rvalid, a_rdata, busy);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      @(posedge clk);
    end
    #2;
    vectors++;
    if ({busy, ram_addrin} !== {1'b1, 3'd4}) begin
      miscompares++;
      $display("FAIL mid_sweep: got busy=%b ain=%0d expected 1/4", busy, ram_addrin);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, ram_wen, ram_addrin} !== {2'b11, 3'd0}) begin
      miscompares++;
      $display("FAIL mid_reset: got busy=%b wen=%b ain=%0d expected 1/1/0", busy, ram_wen, ram_addrin);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < D; i++) begin
      #1;
      vectors++;
      if ({busy, ram_wen, ram_addrin} !== {2'b11, AW'(i)}) begin
        miscompares++;
        $display("FAIL resweep_%0d: got busy=%b wen=%b ain=%0d expected 1/1/%0d", i, busy, ram_wen, ram_addrin, i);
      end
      @(posedge clk);
    end
    #2;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL resweep_end: busy got %b expected 0", busy);
    end
  endtask

  initial begin
    model_reset();
    a_act = 1'b0; b_act = 1'b0;
    test_reset();
    test_sweep();
    test_read_zero();
    test_write_read();
    test_random();
    test_alternate();
    test_conflict();
    test_b_reads();
    test_reset_mid_sweep();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before the bench completed");
    $fatal(1);
  end

endmodule
